// File: rtl/alu_lockstep_sched.sv
// Round-robin front end for a dual-lane lockstep ALU: issues one operation to both lanes,
// compares the lane results and returns lane-1 data. Optional macro: ALU_LOCKSTEP_RETRY_EN.
module alu_lockstep_sched (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req1_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_b,
  input  logic [1:0] req0_sel,
  input  logic [1:0] req1_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_out1,
  input  logic [3:0] alu_out2,
  input  logic       alu_cout1,
  input  logic       alu_cout2,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StCmp, StResp} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0] alu_sel_q, alu_sel_d;
  logic       rsp_id_q, rsp_id_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       grant0, grant1, match, fail;
`ifdef ALU_LOCKSTEP_RETRY_EN
  logic       retry_q, retry_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    err_cnt_d    = err_cnt_q;
    fail         = 1'b0;
`ifdef ALU_LOCKSTEP_RETRY_EN
    retry_d      = retry_q;
`endif

    // Tie goes to whichever requester was not served last.
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = (state_q == StIdle) && !wb_rst_i && grant0;
    req1_ready = (state_q == StIdle) && !wb_rst_i && grant1;
    match      = (alu_out1 == alu_out2) && (alu_cout1 == alu_cout2);

    unique case (state_q)
      StIdle: begin
        if (req0_ready) begin
          alu_a_d      = req0_a;
          alu_b_d      = req0_b;
          alu_sel_d    = req0_sel;
          rsp_id_d     = 1'b0;
          last_grant_d = 1'b0;
          state_d      = StWait;
        end else if (req1_ready) begin
          alu_a_d      = req1_a;
          alu_b_d      = req1_b;
          alu_sel_d    = req1_sel;
          rsp_id_d     = 1'b1;
          last_grant_d = 1'b1;
          state_d      = StWait;
        end
      end
      StWait: state_d = StCmp;
      StCmp: begin
        rsp_data_d  = alu_out1;
        rsp_carry_d = alu_cout1;
        rsp_err_d   = 1'b0;
        state_d     = StResp;
        if (!match) begin
`ifdef ALU_LOCKSTEP_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = StWait;
          end else begin
            fail = 1'b1;
          end
`else
          fail = 1'b1;
`endif
        end
        if (fail) begin
          rsp_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
`ifdef ALU_LOCKSTEP_RETRY_EN
        if (state_d == StResp) retry_d = 1'b0;
`endif
      end
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_sel_q    <= 2'd0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 4'd0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
`ifdef ALU_LOCKSTEP_RETRY_EN
      retry_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
      err_cnt_q    <= err_cnt_d;
`ifdef ALU_LOCKSTEP_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
